// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_pkg
// Description : Shared constants and types for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

    localparam int REG_IDX_W                = 4;
    localparam int DEFAULT_SRAM_WAIT_CYCLES = 4;

    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_WAIT = 2'd1;
    localparam logic [1:0] CTRL_DONE = 2'd2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_hazard_detect_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect_unit
// Description : Combinational RAW hazard detection between ID and EXE/MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect_unit
    import pipeline_hazard_controller_pkg::*;
(
    input  logic     enable_forwarding,
    input  reg_idx_t id_src1,
    input  reg_idx_t id_src2,
    input  logic     id_two_src,
    input  logic     id_uses_src1,
    input  reg_idx_t exe_dest,
    input  logic     exe_wb_en,
    input  logic     exe_mem_read,
    input  reg_idx_t mem_dest,
    input  logic     mem_wb_en,
    output logic     raw
);

    logic w_hit_exe;
    logic w_hit_mem;

    assign w_hit_exe = (id_uses_src1 & (id_src1 == exe_dest)) |
                       (id_two_src   & (id_src2 == exe_dest));
    assign w_hit_mem = (id_uses_src1 & (id_src1 == mem_dest)) |
                       (id_two_src   & (id_src2 == mem_dest));

    // With forwarding, only a load in EXE cannot supply its result in time.
    assign raw = enable_forwarding ? (exe_mem_read & w_hit_exe)
                                   : ((exe_wb_en & w_hit_exe) | (mem_wb_en & w_hit_mem));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Freeze/flush/stall sequencing for the 5-stage core, with an
//               SRAM wait-state FSM. Optional HAZARD_PERF_COUNTERS_EN adds
//               stall/freeze/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int SRAM_WAIT_CYCLES = DEFAULT_SRAM_WAIT_CYCLES,
    parameter int CNT_W            = 4
)(
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_COUNTERS_EN
    input  logic        perf_clear,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_freeze_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    input  logic        enable_forwarding,
    input  reg_idx_t    ID_src1,
    input  reg_idx_t    ID_src2,
    input  logic        ID_two_src,
    input  logic        ID_uses_src1,
    input  reg_idx_t    EXE_dest,
    input  logic        EXE_wb_en,
    input  logic        EXE_mem_read,
    input  reg_idx_t    MEM_dest,
    input  logic        MEM_wb_en,
    input  logic        MEM_mem_r_en,
    input  logic        MEM_mem_w_en,
    input  logic        EXE_branch_taken,
    output logic        freeze,
    output logic        hazard_stall,
    output logic        flush,
    output logic        mem_ready,
    output logic [1:0]  ctrl_state
);

    // The IDLE cycle is the first frozen cycle, so WAIT covers the remaining count.
    localparam logic [CNT_W-1:0] c_load =
        CNT_W'((SRAM_WAIT_CYCLES >= 2) ? (SRAM_WAIT_CYCLES - 2) : 0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_counter;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_counter;
    logic             w_mem_req;
    logic             w_freeze;
    logic             w_raw;

    assign w_mem_req = MEM_mem_r_en | MEM_mem_w_en;

    always_comb begin
        w_next_state   = r_state;
        w_next_counter = r_counter;
        w_freeze       = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (w_mem_req) begin
                    w_freeze = 1'b1;
                    if (SRAM_WAIT_CYCLES == 1) begin
                        w_next_state = CTRL_DONE;
                    end else begin
                        w_next_counter = c_load;
                        w_next_state   = CTRL_WAIT;
                    end
                end
            end
            CTRL_WAIT: begin
                w_freeze = 1'b1;
                if (r_counter == '0) begin
                    w_next_state = CTRL_DONE;
                end else begin
                    w_next_counter = r_counter - CNT_W'(1);
                end
            end
            CTRL_DONE: w_next_state = CTRL_IDLE;
            default:   w_next_state = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CTRL_IDLE;
            r_counter <= '0;
        end else begin
            r_state   <= w_next_state;
            r_counter <= w_next_counter;
        end
    end

    hazard_detect_unit u_hazard_detect_unit (
        .enable_forwarding (enable_forwarding),
        .id_src1           (ID_src1),
        .id_src2           (ID_src2),
        .id_two_src        (ID_two_src),
        .id_uses_src1      (ID_uses_src1),
        .exe_dest          (EXE_dest),
        .exe_wb_en         (EXE_wb_en),
        .exe_mem_read      (EXE_mem_read),
        .mem_dest          (MEM_dest),
        .mem_wb_en         (MEM_wb_en),
        .raw               (w_raw)
    );

    // A branch held during a freeze flushes in the first unfrozen cycle.
    assign freeze       = w_freeze;
    assign flush        = EXE_branch_taken & ~w_freeze;
    assign hazard_stall = w_raw & ~w_freeze & ~flush;
    assign mem_ready    = (r_state == CTRL_DONE);
    assign ctrl_state   = r_state;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_freeze_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (hazard_stall && (r_stall_cnt != '1))  r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (w_freeze && (r_freeze_cnt != '1))     r_freeze_cnt <= r_freeze_cnt + 32'd1;
            if (flush && (r_flush_cnt != '1))         r_flush_cnt  <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_freeze_cnt = r_freeze_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Self-checking bench for pipeline_hazard_controller (wait 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       perf_clear;
    logic       enable_forwarding;
    logic [3:0] ID_src1, ID_src2, EXE_dest, MEM_dest;
    logic       ID_two_src, ID_uses_src1, EXE_wb_en, EXE_mem_read, MEM_wb_en;
    logic       MEM_mem_r_en, MEM_mem_w_en, EXE_branch_taken;

    logic       freeze[2], hazard_stall[2], flush[2], mem_ready[2];
    logic [1:0] ctrl_state[2];
    logic [31:0] pc_stall[2], pc_freeze[2], pc_flush[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.SRAM_WAIT_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
`ifdef HAZARD_PERF_COUNTERS_EN
        .perf_clear(perf_clear), .perf_stall_cnt(pc_stall[0]),
        .perf_freeze_cnt(pc_freeze[0]), .perf_flush_cnt(pc_flush[0]),
`endif
        .enable_forwarding(enable_forwarding), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src), .ID_uses_src1(ID_uses_src1), .EXE_dest(EXE_dest),
        .EXE_wb_en(EXE_wb_en), .EXE_mem_read(EXE_mem_read), .MEM_dest(MEM_dest),
        .MEM_wb_en(MEM_wb_en), .MEM_mem_r_en(MEM_mem_r_en), .MEM_mem_w_en(MEM_mem_w_en),
        .EXE_branch_taken(EXE_branch_taken), .freeze(freeze[0]),
        .hazard_stall(hazard_stall[0]), .flush(flush[0]), .mem_ready(mem_ready[0]),
        .ctrl_state(ctrl_state[0])
    );

    pipeline_hazard_controller #(.SRAM_WAIT_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
`ifdef HAZARD_PERF_COUNTERS_EN
        .perf_clear(perf_clear), .perf_stall_cnt(pc_stall[1]),
        .perf_freeze_cnt(pc_freeze[1]), .perf_flush_cnt(pc_flush[1]),
`endif
        .enable_forwarding(enable_forwarding), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src), .ID_uses_src1(ID_uses_src1), .EXE_dest(EXE_dest),
        .EXE_wb_en(EXE_wb_en), .EXE_mem_read(EXE_mem_read), .MEM_dest(MEM_dest),
        .MEM_wb_en(MEM_wb_en), .MEM_mem_r_en(MEM_mem_r_en), .MEM_mem_w_en(MEM_mem_w_en),
        .EXE_branch_taken(EXE_branch_taken), .freeze(freeze[1]),
        .hazard_stall(hazard_stall[1]), .flush(flush[1]), .mem_ready(mem_ready[1]),
        .ctrl_state(ctrl_state[1])
    );

    typedef struct {
        string      name;
        bit         fwd;
        logic [3:0] s1, s2;
        bit         two, use1;
        logic [3:0] ed;
        bit         ewb, emr;
        logic [3:0] md;
        bit         mwb, br;
        bit         exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[9];

    // Reference model: remaining frozen cycles and a pending ready cycle per instance.
    int swc[2] = '{4, 1};
    int rem[2];
    bit done[2];
    longint m_stall[2], m_freeze[2], m_flush[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        perf_clear = 0; enable_forwarding = 0;
        ID_src1 = 0; ID_src2 = 0; ID_two_src = 0; ID_uses_src1 = 0;
        EXE_dest = 0; EXE_wb_en = 0; EXE_mem_read = 0;
        MEM_dest = 0; MEM_wb_en = 0; MEM_mem_r_en = 0; MEM_mem_w_en = 0;
        EXE_branch_taken = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 1;
        clear_inputs();
        step();
        rst = 0;
    endtask

    function automatic bit model_raw();
        bit hit_exe, hit_mem;
        hit_exe = (ID_uses_src1 && ID_src1 == EXE_dest) || (ID_two_src && ID_src2 == EXE_dest);
        hit_mem = (ID_uses_src1 && ID_src1 == MEM_dest) || (ID_two_src && ID_src2 == MEM_dest);
        if (enable_forwarding) return EXE_mem_read && hit_exe;
        return (EXE_wb_en && hit_exe) || (MEM_wb_en && hit_mem);
    endfunction

    initial begin
        bit req, e_frz, e_fl, e_st, e_rdy;
        int e_state;

        vecs[0] = '{"load_use_fwd",   1, 3, 0, 0, 1, 3, 1, 1, 0, 0, 0, 1, 0};
        vecs[1] = '{"no_load_fwd",    1, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"mem_hz_nofwd",   0, 0, 5, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0};
        vecs[3] = '{"mem_hz_one_src", 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0};
        vecs[4] = '{"exe_hz_nofwd",   0, 7, 0, 0, 1, 7, 1, 0, 9, 0, 0, 1, 0};
        vecs[5] = '{"mem_only_fwd",   1, 6, 0, 0, 1, 2, 1, 1, 6, 1, 0, 0, 0};
        vecs[6] = '{"branch_over_hz", 0, 7, 0, 0, 1, 7, 1, 0, 9, 0, 1, 0, 1};
        vecs[7] = '{"no_match",       0, 1, 4, 1, 1, 2, 1, 0, 8, 1, 0, 0, 0};
        vecs[8] = '{"src1_unused",    0, 7, 0, 0, 0, 7, 1, 0, 7, 1, 0, 0, 0};

        rst = 1;
        clear_inputs();
        repeat (2) step();
        rst = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_state",  {30'd0, ctrl_state[k]}, 0);
            check("rst_freeze", {31'd0, freeze[k]}, 0);
            check("rst_stall",  {31'd0, hazard_stall[k]}, 0);
            check("rst_flush",  {31'd0, flush[k]}, 0);
            check("rst_ready",  {31'd0, mem_ready[k]}, 0);
        end

        // Combinational hazard/flush table with the FSM idle.
        foreach (vecs[i]) begin
            step();
            enable_forwarding = vecs[i].fwd; ID_src1 = vecs[i].s1; ID_src2 = vecs[i].s2;
            ID_two_src = vecs[i].two; ID_uses_src1 = vecs[i].use1; EXE_dest = vecs[i].ed;
            EXE_wb_en = vecs[i].ewb; EXE_mem_read = vecs[i].emr; MEM_dest = vecs[i].md;
            MEM_wb_en = vecs[i].mwb; EXE_branch_taken = vecs[i].br;
            @(negedge clk);
            check({vecs[i].name, "_stall"}, {31'd0, hazard_stall[0]}, {31'd0, vecs[i].exp_stall});
            check({vecs[i].name, "_flush"}, {31'd0, flush[0]}, {31'd0, vecs[i].exp_flush});
            check({vecs[i].name, "_freeze"}, {31'd0, freeze[0]}, 0);
        end

        // SRAM read with 4 wait cycles; request ignored in DONE.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            MEM_mem_r_en = (c <= 4);
            @(negedge clk);
            check($sformatf("rd_freeze_c%0d", c), {31'd0, freeze[0]}, (c <= 3) ? 1 : 0);
            check($sformatf("rd_ready_c%0d", c), {31'd0, mem_ready[0]}, (c == 4) ? 1 : 0);
            check($sformatf("rd_state_c%0d", c), {30'd0, ctrl_state[0]},
                  (c == 0 || c == 5) ? 0 : (c == 4) ? 2 : 1);
        end

        // Reset in the middle of WAIT abandons the access.
        do_reset();
        step(); MEM_mem_r_en = 1;
        step();
        step(); rst = 1;
        step(); rst = 0; MEM_mem_r_en = 0;
        @(negedge clk);
        check("midrst_state", {30'd0, ctrl_state[0]}, 0);
        check("midrst_freeze", {31'd0, freeze[0]}, 0);
        for (int c = 0; c < 6; c++) begin
            check("midrst_no_ready", {31'd0, mem_ready[0]}, 0);
            step();
            @(negedge clk);
        end

        // Taken branch plus RAW while frozen: flush waits for the DONE cycle.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            MEM_mem_r_en = 1; EXE_branch_taken = 1; enable_forwarding = 0;
            EXE_wb_en = 1; EXE_dest = 3; ID_src1 = 3; ID_uses_src1 = 1;
            @(negedge clk);
            check($sformatf("brfz_flush_c%0d", c), {31'd0, flush[0]}, (c == 4) ? 1 : 0);
            check($sformatf("brfz_stall_c%0d", c), {31'd0, hazard_stall[0]}, 0);
            check($sformatf("brfz_freeze_c%0d", c), {31'd0, freeze[0]}, (c == 4) ? 0 : 1);
        end

        // One wait cycle, back-to-back writes.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            MEM_mem_w_en = 1;
            @(negedge clk);
            check($sformatf("b2b_freeze_c%0d", c), {31'd0, freeze[1]}, (c % 2 == 0) ? 1 : 0);
            check($sformatf("b2b_ready_c%0d", c), {31'd0, mem_ready[1]}, (c % 2 == 1) ? 1 : 0);
        end
        step();
        MEM_mem_w_en = 0;
        @(negedge clk);
`ifdef HAZARD_PERF_COUNTERS_EN
        check("b2b_perf_freeze", pc_freeze[1], 2);
        check("b2b_perf_stall", pc_stall[1], 0);
`endif

        // Randomized run against the reference model for both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; done[k] = 0; m_stall[k] = 0; m_freeze[k] = 0; m_flush[k] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            step();
            rst               = ($urandom_range(0, 99) == 0);
            perf_clear        = ($urandom_range(0, 39) == 0);
            enable_forwarding = $urandom_range(0, 1);
            ID_src1 = 4'($urandom_range(0, 3)); ID_src2 = 4'($urandom_range(0, 3));
            EXE_dest = 4'($urandom_range(0, 3)); MEM_dest = 4'($urandom_range(0, 3));
            ID_two_src = $urandom_range(0, 1); ID_uses_src1 = $urandom_range(0, 1);
            EXE_wb_en = $urandom_range(0, 1); EXE_mem_read = $urandom_range(0, 1);
            MEM_wb_en = $urandom_range(0, 1);
            MEM_mem_r_en = ($urandom_range(0, 5) == 0);
            MEM_mem_w_en = ($urandom_range(0, 5) == 0);
            EXE_branch_taken = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            req = MEM_mem_r_en || MEM_mem_w_en;
            for (int k = 0; k < 2; k++) begin
                e_rdy   = done[k];
                e_frz   = done[k] ? 1'b0 : (rem[k] > 0) ? 1'b1 : req;
                e_state = done[k] ? 2 : (rem[k] > 0) ? 1 : 0;
                e_fl    = EXE_branch_taken && !e_frz;
                e_st    = model_raw() && !e_frz && !e_fl;
                check($sformatf("rnd%0d_freeze", k), {31'd0, freeze[k]}, {31'd0, e_frz});
                check($sformatf("rnd%0d_flush", k), {31'd0, flush[k]}, {31'd0, e_fl});
                check($sformatf("rnd%0d_stall", k), {31'd0, hazard_stall[k]}, {31'd0, e_st});
                check($sformatf("rnd%0d_ready", k), {31'd0, mem_ready[k]}, {31'd0, e_rdy});
                check($sformatf("rnd%0d_state", k), {30'd0, ctrl_state[k]}, 32'(e_state));
`ifdef HAZARD_PERF_COUNTERS_EN
                check($sformatf("rnd%0d_pstall", k), pc_stall[k], 32'(m_stall[k]));
                check($sformatf("rnd%0d_pfreeze", k), pc_freeze[k], 32'(m_freeze[k]));
                check($sformatf("rnd%0d_pflush", k), pc_flush[k], 32'(m_flush[k]));
`endif
                if (rst || perf_clear) begin
                    m_stall[k] = 0; m_freeze[k] = 0; m_flush[k] = 0;
                end else begin
                    if (e_st)  m_stall[k]  = (m_stall[k]  < 64'hFFFFFFFF) ? m_stall[k]  + 1 : m_stall[k];
                    if (e_frz) m_freeze[k] = (m_freeze[k] < 64'hFFFFFFFF) ? m_freeze[k] + 1 : m_freeze[k];
                    if (e_fl)  m_flush[k]  = (m_flush[k]  < 64'hFFFFFFFF) ? m_flush[k]  + 1 : m_flush[k];
                end
                if (rst) begin
                    rem[k] = 0; done[k] = 0;
                end else if (done[k]) begin
                    done[k] = 0;
                end else if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) done[k] = 1;
                end else if (req) begin
                    rem[k] = swc[k] - 1;
                    if (rem[k] == 0) done[k] = 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central pipeline sequencing block for the 5-stage ARM core.
- Detects RAW hazards in ID and stalls IF/ID with a bubble into EXE; without forwarding it catches all RAW hazards, with forwarding only load-use.
- Freezes the whole pipeline during multi-cycle SRAM accesses in MEM, using an internal wait-state FSM.
- Flushes IF/ID and ID/EXE on a taken branch, and arbitrates priority between freeze, stall and flush.

Parameters:
- SRAM_WAIT_CYCLES, 4, freeze cycles per data-memory access; legal range 1..15.
- CNT_W, 4, width of the wait-state counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- enable_forwarding  input  1  1 = forwarding unit active, so only load-use hazards stall.
- ID_src1  input  4  first source register of the instruction in ID.
- ID_src2  input  4  second source register of the instruction in ID.
- ID_two_src  input  1  ID_src2 is a real operand.
- ID_uses_src1  input  1  ID_src1 is a real operand.
- EXE_dest  input  4  destination register in EXE.
- EXE_wb_en  input  1  EXE writes back.
- EXE_mem_read  input  1  EXE is a load.
- MEM_dest  input  4  destination register in MEM.
- MEM_wb_en  input  1  MEM writes back.
- MEM_mem_r_en  input  1  MEM performs an SRAM read.
- MEM_mem_w_en  input  1  MEM performs an SRAM write.
- EXE_branch_taken  input  1  branch resolved taken in EXE.
- freeze  output  1  all pipeline registers hold; SRAM access in progress.
- hazard_stall  output  1  PC and IF/ID hold; ID/EXE loads a bubble.
- flush  output  1  IF/ID and ID/EXE cleared.
- mem_ready  output  1  one-cycle pulse: SRAM data valid, MEM/WB may capture.
- ctrl_state  output  2  FSM state, for debug.

Behaviour:
- All state updates on posedge clk. rst synchronous, active-high; reset clears the FSM and counter.
- Reset values, and values in the cycle after reset: ctrl_state=IDLE(2'd0), counter=0, freeze=0, hazard_stall=0, flush=0, mem_ready=0.
- Reset asserted mid-access abandons the access immediately; no mem_ready is produced.
- mem_req = MEM_mem_r_en | MEM_mem_w_en.
- FSM states:
  - IDLE (0):
    - mem_req=0: freeze=0.
    - mem_req=1: freeze=1 in the same cycle (combinational).
    - mem_req=1 and SRAM_WAIT_CYCLES==1: next state DONE.
    - mem_req=1 otherwise: counter loaded with SRAM_WAIT_CYCLES-2; next state WAIT.
  - WAIT (1):
    - freeze=1.
    - counter==0: next state DONE.
    - otherwise: counter decrements.
  - DONE (2):
    - freeze=0, mem_ready=1; pipeline advances; next state IDLE.
    - mem_req is ignored in DONE; the instruction entering MEM is seen in IDLE on the next cycle.
  - State 3 is unreachable; if entered, next state is IDLE with freeze=0.
- Total freeze per access = SRAM_WAIT_CYCLES cycles, followed by exactly one mem_ready cycle.
- Back-to-back accesses therefore cost SRAM_WAIT_CYCLES+1 cycles each.
- Hazard detection is combinational from ID/EXE/MEM inputs:
  - m1 = ID_uses_src1 & (ID_src1 == X_dest), where X is EXE or MEM.
  - m2 = ID_two_src & (ID_src2 == X_dest), where X is EXE or MEM.
  - Forwarding off: raw = (EXE_wb_en & (m1_exe|m2_exe)) | (MEM_wb_en & (m1_mem|m2_mem)).
  - Forwarding on: raw = EXE_mem_read & (m1_exe|m2_exe).
- Priority: freeze > flush > hazard_stall.
  - flush = EXE_branch_taken & ~freeze. A branch held in EXE during a freeze flushes in the first unfrozen cycle.
  - hazard_stall = raw & ~freeze & ~flush. The instruction in ID is being flushed, so no stall.
- Outputs other than ctrl_state and mem_ready are combinational; no added latency.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- When defined, adds:
  - outputs perf_stall_cnt[31:0], perf_freeze_cnt[31:0], perf_flush_cnt[31:0];
  - input perf_clear.
- Each counter increments by 1 on every cycle its signal is 1, and saturates at 32'hFFFFFFFF.
- rst or perf_clear zeroes all three counters; clear wins over a same-cycle increment.
- When undefined, the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package/defines file holds:
  - FSM state encodings CTRL_IDLE / CTRL_WAIT / CTRL_DONE;
  - register-index width 4;
  - default SRAM_WAIT_CYCLES.
- One natural sub-module: hazard_detect_unit, the pure combinational raw computation, instantiated once.
- The FSM, counter and priority logic stay in the top.

Test Plan:
- Reset mid-WAIT: SRAM_WAIT_CYCLES=4, assert MEM_mem_r_en, then rst on cycle 2 -> next cycle ctrl_state=0, freeze=0, no mem_ready pulse ever.
- SRAM read, SRAM_WAIT_CYCLES=4: MEM_mem_r_en=1 from cycle 0 -> freeze=1 on cycles 0-3, mem_ready=1 and freeze=0 on cycle 4, IDLE on cycle 5.
- Load-use with forwarding: enable_forwarding=1, EXE_mem_read=1, EXE_dest=3, EXE_wb_en=1, ID_src1=3 -> hazard_stall=1. Same stimulus with EXE_mem_read=0 -> hazard_stall=0.
- No-forwarding MEM hazard: enable_forwarding=0, MEM_dest=5, MEM_wb_en=1, ID_src2=5, ID_two_src=1 -> hazard_stall=1. Same with ID_two_src=0 -> 0.
- Branch during freeze: EXE_branch_taken=1 while in WAIT -> flush=0 until the DONE cycle, then flush=1 there with hazard_stall=0 even if raw=1.
- SRAM_WAIT_CYCLES=1 back-to-back writes: MEM_mem_w_en held high -> freeze pattern 1,0,1,0; mem_ready on every DONE cycle. With HAZARD_PERF_COUNTERS_EN, perf_freeze_cnt=2 after 4 cycles.
